// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types, S-box, xtime and key-schedule FSM states
// Purpose: common definitions for the AES key schedule and cipher datapath.
// Contents: aes_word_t / aes_block_t, AES_RCON_INIT, key_exp_state_e,
//           aes_sbox() byte substitution, xtime() GF(2^8) doubling.
package aes_pkg;

  typedef logic [31:0]  aes_word_t;
  typedef logic [127:0] aes_block_t;

  localparam logic [7:0] AES_RCON_INIT = 8'h01;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    DONE
  } key_exp_state_e;

  // Entry 0 sits in the MSBs so the table reads in the usual row order.
  localparam logic [2047:0] AES_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] aes_sbox(input logic [7:0] b);
    logic [10:0] pos;
    // (255 - b) * 8 == ~b << 3
    pos = {~b, 3'b000};
    return AES_SBOX[pos +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_key_expand_if.sv
// rtl/aes_key_expand_if.sv - key-schedule load/status/round-key bundle
// Purpose: groups the key schedule's load strobe, key, status and round keys.
// Signals: key_load, key[32*Nk-1:0], busy, key_valid, k_sch[0:Nr],
//          zeroize (only when AES_KEY_ZEROIZE_EN is defined).
// Modports: master (key source / cipher side), slave (aes_key_expand).
interface aes_key_expand_if
  import aes_pkg::*;
#(
  parameter int Nk = 4
);
  localparam int Nr = Nk + 6;

  logic              key_load;
  logic [32*Nk-1:0]  key;
  logic              busy;
  logic              key_valid;
  aes_block_t        k_sch [0:Nr];
`ifdef AES_KEY_ZEROIZE_EN
  logic              zeroize;
`endif

`ifdef AES_KEY_ZEROIZE_EN
  modport master (output key_load, key, zeroize, input busy, key_valid, k_sch);
  modport slave  (input key_load, key, zeroize, output busy, key_valid, k_sch);
`else
  modport master (output key_load, key, input busy, key_valid, k_sch);
  modport slave  (input key_load, key, output busy, key_valid, k_sch);
`endif

endinterface

// File: rtl/aes_sub_word.sv
// rtl/aes_sub_word.sv - SubWord: four parallel S-box lookups on a 32-bit word
// Purpose: combinational byte substitution, shared with the cipher datapath.
// Ports: in_word (32b in), out_word (32b out, SubWord(in_word)).
module aes_sub_word
  import aes_pkg::*;
(
  input  aes_word_t in_word,
  output aes_word_t out_word
);

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    assign out_word[8*b +: 8] = aes_sbox(in_word[8*b +: 8]);
  end

endmodule

// File: rtl/aes_key_expand.sv
// rtl/aes_key_expand.sv - iterative AES key expansion, one schedule word per clock
// Purpose: loads a 128/192/256-bit key and builds the full round-key schedule,
//          holding it in registers for the downstream cipher core.
// Ports: clk, rst_n (async active-low), kif (aes_key_expand_if.slave):
//        key_load/key in; busy/key_valid/k_sch out; zeroize in when the
//        AES_KEY_ZEROIZE_EN macro is defined.
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int Nk = 4,
  parameter int Nr = Nk + 6
)(
  input  logic                clk,
  input  logic                rst_n,
  aes_key_expand_if.slave     kif
);

  localparam int NW = 4 * (Nr + 1);
  localparam int IW = $clog2(NW);

  if (!(Nk == 4 || Nk == 6 || Nk == 8)) begin : g_bad_nk
    $error("aes_key_expand: Nk must be 4, 6 or 8");
  end
  if (Nr != Nk + 6) begin : g_bad_nr
    $error("aes_key_expand: Nr is derived from Nk and must not be overridden");
  end

  key_exp_state_e  state, state_nxt;
  aes_word_t       w [0:NW-1];
  logic [IW-1:0]   idx;
  logic [2:0]      imod;
  logic [7:0]      rcon;

  logic            zero_req;
  logic            last_word;
  logic            rot_step;
  aes_word_t       prev_word, back_word, sub_in, sub_out, temp;

`ifdef AES_KEY_ZEROIZE_EN
  assign zero_req = kif.zeroize;
`else
  assign zero_req = 1'b0;
`endif

  assign last_word = (idx == IW'(NW - 1));

  // FSM: zeroize beats key_load; key_load restarts from any state.
  always_comb begin
    state_nxt = state;
    if (zero_req) begin
      state_nxt = IDLE;
    end else if (kif.key_load) begin
      state_nxt = EXPAND;
    end else begin
      case (state)
        EXPAND:  if (last_word) state_nxt = DONE;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-word datapath. idx/back references are only meaningful in EXPAND.
  always_comb begin
    prev_word = w[idx - IW'(1)];
    back_word = w[idx - IW'(Nk)];
    rot_step  = (imod == 3'd0);
    sub_in    = rot_step ? {prev_word[23:0], prev_word[31:24]} : prev_word;
    temp      = prev_word;
    if (rot_step) begin
      temp = sub_out ^ {rcon, 24'h0};
    end else if (Nk == 8 && imod == 3'd4) begin
      temp = sub_out;
    end
  end

  aes_sub_word u_sub_word (
    .in_word  (sub_in),
    .out_word (sub_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NW; k++) w[k] <= '0;
      idx  <= '0;
      imod <= '0;
      rcon <= AES_RCON_INIT;
    end else if (zero_req) begin
      for (int k = 0; k < NW; k++) w[k] <= '0;
      idx  <= '0;
      imod <= '0;
      rcon <= AES_RCON_INIT;
    end else if (kif.key_load) begin
      // First key byte is in the MSBs, so w[0] is the top word.
      for (int k = 0; k < Nk; k++) w[k] <= kif.key[32*(Nk-k)-1 -: 32];
      idx  <= IW'(Nk);
      imod <= '0;
      rcon <= AES_RCON_INIT;
    end else if (state == EXPAND) begin
      w[idx] <= back_word ^ temp;
      idx    <= idx + IW'(1);
      imod   <= (imod == 3'(Nk - 1)) ? 3'd0 : imod + 3'd1;
      if (rot_step) rcon <= xtime(rcon);
    end
  end

  // Status decodes straight from the state register: no input-to-output path.
  assign kif.busy      = (state == EXPAND);
  assign kif.key_valid = (state == DONE);

  for (genvar r = 0; r <= Nr; r++) begin : g_ksch
    assign kif.k_sch[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  end

endmodule

// File: tb/tb_aes_key_expand.sv
// tb/tb_aes_key_expand.sv - scoreboard bench for aes_key_expand at Nk = 4, 6, 8
module tb_aes_key_expand;
  import aes_pkg::*;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  localparam logic [127:0] KEY4 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [191:0] KEY6 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] KEY8 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  aes_key_expand_if #(.Nk(4)) if4 ();
  aes_key_expand_if #(.Nk(6)) if6 ();
  aes_key_expand_if #(.Nk(8)) if8 ();

  aes_key_expand #(.Nk(4)) d4 (.clk(clk), .rst_n(rst_n), .kif(if4));
  aes_key_expand #(.Nk(6)) d6 (.clk(clk), .rst_n(rst_n), .kif(if6));
  aes_key_expand #(.Nk(8)) d8 (.clk(clk), .rst_n(rst_n), .kif(if8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int           dut;
    int           rnd;
    logic [127:0] val;
    string        name;
  } exp_t;

  exp_t sb[$];

  function automatic logic [127:0] ksch(input int dut, input int r);
    case (dut)
      4:       return if4.k_sch[r];
      6:       return if6.k_sch[r];
      default: return if8.k_sch[r];
    endcase
  endfunction

  function automatic logic kv(input int dut);
    case (dut)
      4:       return if4.key_valid;
      6:       return if6.key_valid;
      default: return if8.key_valid;
    endcase
  endfunction

  function automatic logic bz(input int dut);
    case (dut)
      4:       return if4.busy;
      6:       return if6.busy;
      default: return if8.busy;
    endcase
  endfunction

  task automatic push(input int dut, input int rnd, input logic [127:0] v, input string nm);
    exp_t e;
    e.dut = dut; e.rnd = rnd; e.val = v; e.name = nm;
    sb.push_back(e);
  endtask

  // Drives a one-cycle key_load; returns at the falling edge after the load edge.
  task automatic load(input int dut, input logic [255:0] k);
    @(negedge clk);
    case (dut)
      4:       begin if4.key = k[127:0]; if4.key_load = 1'b1; end
      6:       begin if6.key = k[191:0]; if6.key_load = 1'b1; end
      default: begin if8.key = k;        if8.key_load = 1'b1; end
    endcase
    @(posedge clk);
    @(negedge clk);
    if4.key_load = 1'b0;
    if6.key_load = 1'b0;
    if8.key_load = 1'b0;
  endtask

  // n counts rising edges, the load edge being edge 1; bounded.
  task automatic wait_valid(input int dut, input int start, output int n);
    n = start;
    while (!kv(dut) && n < start + 200) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({bz(4), bz(6), bz(8)} !== 3'b000)
      begin failures++; $display("FAIL reset_busy: got %b want 000", {bz(4), bz(6), bz(8)}); end
    checks++;
    if ({kv(4), kv(6), kv(8)} !== 3'b000)
      begin failures++; $display("FAIL reset_valid: got %b want 000", {kv(4), kv(6), kv(8)}); end
    checks++;
    if ((if4.k_sch[0] | if4.k_sch[10] | if6.k_sch[12] | if8.k_sch[14]) !== 128'h0)
      begin failures++; $display("FAIL reset_ksch: some round key nonzero"); end
  endtask

  task automatic test_nk(input int dut, input int lat);
    int n;
    exp_t e;
    logic [127:0] act;
    case (dut)
      4: begin
        push(4, 0,  KEY4, "nk4_k0");
        push(4, 1,  128'ha0fafe1788542cb123a339392a6c7605, "nk4_k1");
        push(4, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "nk4_k10");
        load(4, {128'h0, KEY4});
      end
      6: begin
        push(6, 0,  KEY6[191:64], "nk6_k0");
        push(6, 12, 128'he98ba06f448c773c8ecc720401002202, "nk6_k12");
        load(6, {64'h0, KEY6});
      end
      default: begin
        push(8, 0,  KEY8[255:128], "nk8_k0");
        push(8, 1,  KEY8[127:0],   "nk8_k1");
        push(8, 14, 128'hfe4890d1e6188d0b046df344706c631e, "nk8_k14");
        load(8, KEY8);
      end
    endcase
    checks++;
    if (bz(dut) !== 1'b1 || kv(dut) !== 1'b0)
      begin failures++; $display("FAIL nk%0d_busy_after_load: busy=%b valid=%b want 1/0", dut, bz(dut), kv(dut)); end
    wait_valid(dut, 1, n);
    checks++;
    if (n !== lat)
      begin failures++; $display("FAIL nk%0d_latency: got %0d edges want %0d", dut, n, lat); end
    checks++;
    if (bz(dut) !== 1'b0 || kv(dut) !== 1'b1)
      begin failures++; $display("FAIL nk%0d_done_flags: busy=%b valid=%b want 0/1", dut, bz(dut), kv(dut)); end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      act = ksch(e.dut, e.rnd);
      checks++;
      if (act !== e.val)
        begin failures++; $display("FAIL %s: got %h want %h", e.name, act, e.val); end
    end
  endtask

  // Starts from DONE: zero-key load drops key_valid, real key aborts it at edge 10.
  task automatic test_back_to_back();
    int n;
    logic stray;
    exp_t e;
    logic [127:0] act;
    load(4, 256'h0);
    checks++;
    if (kv(4) !== 1'b0)
      begin failures++; $display("FAIL reload_valid_drop: got %b want 0", kv(4)); end
    stray = 1'b0;
    for (n = 1; n < 9; ) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (kv(4) !== 1'b0) stray = 1'b1;
    end
    push(4, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "abort_k10");
    if4.key = KEY4;
    if4.key_load = 1'b1;
    @(posedge clk);
    n++;
    @(negedge clk);
    if4.key_load = 1'b0;
    while (!kv(4) && n < 200) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (n < 50 && kv(4) !== 1'b0) stray = 1'b1;
    end
    checks++;
    if (stray !== 1'b0)
      begin failures++; $display("FAIL abort_early_valid: key_valid rose before edge 50"); end
    // Set by edge 50, so an edge-51 sampler is the first to see it.
    checks++;
    if (n !== 50)
      begin failures++; $display("FAIL abort_latency: got edge %0d want 50", n); end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      act = ksch(e.dut, e.rnd);
      checks++;
      if (act !== e.val)
        begin failures++; $display("FAIL %s: got %h want %h", e.name, act, e.val); end
    end
  endtask

  task automatic test_reset_midrun();
    int n;
    logic nz;
    exp_t e;
    logic [127:0] act;
    load(4, {128'h0, KEY4});
    repeat (19) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (bz(4) !== 1'b0 || kv(4) !== 1'b0)
      begin failures++; $display("FAIL midrun_reset_flags: busy=%b valid=%b want 0/0", bz(4), kv(4)); end
    nz = 1'b0;
    for (int r = 0; r <= 10; r++) if (if4.k_sch[r] !== 128'h0) nz = 1'b1;
    checks++;
    if (nz !== 1'b0)
      begin failures++; $display("FAIL midrun_reset_ksch: got nonzero round key want all 0"); end
    @(negedge clk);
    rst_n = 1'b1;
    push(4, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "post_reset_k10");
    load(4, {128'h0, KEY4});
    wait_valid(4, 1, n);
    checks++;
    if (n !== 41)
      begin failures++; $display("FAIL post_reset_latency: got %0d want 41", n); end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      act = ksch(e.dut, e.rnd);
      checks++;
      if (act !== e.val)
        begin failures++; $display("FAIL %s: got %h want %h", e.name, act, e.val); end
    end
  endtask

`ifdef AES_KEY_ZEROIZE_EN
  task automatic test_zeroize();
    logic nz;
    @(negedge clk);
    if4.zeroize = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if4.zeroize = 1'b0;
    nz = 1'b0;
    for (int r = 0; r <= 10; r++) if (if4.k_sch[r] !== 128'h0) nz = 1'b1;
    checks++;
    if (nz !== 1'b0 || kv(4) !== 1'b0 || bz(4) !== 1'b0)
      begin failures++; $display("FAIL zeroize_done: valid=%b busy=%b nz=%b want 0/0/0", kv(4), bz(4), nz); end
    if4.zeroize  = 1'b1;
    if4.key_load = 1'b1;
    if4.key      = KEY4;
    @(posedge clk);
    @(negedge clk);
    if4.zeroize  = 1'b0;
    if4.key_load = 1'b0;
    checks++;
    if (bz(4) !== 1'b0 || if4.k_sch[0] !== 128'h0)
      begin failures++; $display("FAIL zeroize_priority: busy=%b k0=%h want 0/0", bz(4), if4.k_sch[0]); end
    repeat (45) @(posedge clk);
    @(negedge clk);
    checks++;
    if (kv(4) !== 1'b0)
      begin failures++; $display("FAIL zeroize_stays_idle: valid=%b want 0", kv(4)); end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    if4.key_load = 1'b0; if4.key = '0;
    if6.key_load = 1'b0; if6.key = '0;
    if8.key_load = 1'b0; if8.key = '0;
`ifdef AES_KEY_ZEROIZE_EN
    if4.zeroize = 1'b0; if6.zeroize = 1'b0; if8.zeroize = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_nk(4, 41);
    test_nk(6, 47);
    test_nk(8, 53);
    test_back_to_back();
    test_reset_midrun();
`ifdef AES_KEY_ZEROIZE_EN
    test_zeroize();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
